dmem_arbiter: RTL and testbench

- Shares the single-port 64-bit data memory between the cardinal processor core and a host/loader port (testbench loader, DMA, NIC).
- Core has fixed priority and zero added latency: its DmemEn, DmemWrEn, Mem_Addr and Data_Out pass straight through.
- Host accesses are buffered in a request FIFO and issued in idle memory cycles.
- Sits between cardinal_processor and the DMEM instance; all buses use big-endian [0:N] bit ordering.

---
 rtl/dmem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port 64-bit data memory between the processor core and a
// host/loader port. The core has fixed priority and zero added latency; host
// requests are queued in a small FIFO and issued in cycles the core leaves idle.
//
// Optional feature macro: STARVE_GUARD_EN
//   When defined, a wait counter forces a one-cycle host slot (core_stall=1)
//   after MAX_WAIT consecutive cycles in which the core blocked a queued host
//   request. When undefined, core_stall is tied low and no counter exists.
//
// Parameters:
//   DEPTH    host request FIFO entries (power of 2, >= 2)
//   MAX_WAIT blocked cycles before a forced host slot (STARVE_GUARD_EN only)
//
// Ports:
//   Clock, Reset            clock; synchronous active-high reset
//   core_en/core_wr_en      core enable / write enable
//   core_addr/core_wdata    core address / store data
//   core_rdata              load data to core (= mem_rdata)
//   host_req/host_wr        host request valid / 1=write 0=read
//   host_addr/host_wdata    host address / write data
//   host_ready              FIFO can accept a request
//   host_rvalid/host_rdata  host read return (1-cycle pulse / held data)
//   mem_en/mem_wr_en        DMEM enable / write enable
//   mem_addr/mem_wdata      DMEM address / write data
//   mem_rdata               DMEM read data, valid the cycle after a read issue
//   core_stall              forced host slot; core must hold its access
module dmem_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        core_en,
    input  logic        core_wr_en,
    input  logic [0:7]  core_addr,
    input  logic [0:63] core_wdata,
    output logic [0:63] core_rdata,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [0:7]  host_addr,
    input  logic [0:63] host_wdata,
    output logic        host_ready,
    output logic        host_rvalid,
    output logic [0:63] host_rdata,
    output logic        mem_en,
    output logic        mem_wr_en,
    output logic [0:7]  mem_addr,
    output logic [0:63] mem_wdata,
    input  logic [0:63] mem_rdata,
    output logic        core_stall
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Request FIFO storage; contents need no reset since count gates validity.
    logic        fifoWr_q   [DEPTH];
    logic [0:7]  fifoAddr_q [DEPTH];
    logic [0:63] fifoData_q [DEPTH];

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rdPending_q, rdPending_d;
    logic [0:63]   rdataHold_q, rdataHold_d;

    logic push;
    logic pop;
    logic notEmpty;
    logic hostIssue;
    logic headWr;
    logic stall;

    assign notEmpty   = (count_q != '0);
    assign host_ready = (count_q < CW'(DEPTH));
    assign push       = host_req && host_ready;
    assign headWr     = fifoWr_q[rdPtr_q];

    // A host slot is taken either when forced by the starvation guard or when
    // the core leaves the memory idle.
    assign hostIssue  = notEmpty && (stall || !core_en);
    assign pop        = hostIssue;

`ifdef STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] waitCnt_q, waitCnt_d;
    logic          coreStall_q, coreStall_d;

    // The counter saturates at MAX_WAIT; stall registers high the cycle after
    // it gets there, which is the cycle that then issues the head and clears it.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (hostIssue) begin
            waitCnt_d = '0;
        end else if (notEmpty && core_en && (waitCnt_q != WW'(MAX_WAIT))) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
        coreStall_d = (waitCnt_d == WW'(MAX_WAIT));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            waitCnt_q   <= '0;
            coreStall_q <= 1'b0;
        end else begin
            waitCnt_q   <= waitCnt_d;
            coreStall_q <= coreStall_d;
        end
    end

    assign stall = coreStall_q;
`else
    assign stall = 1'b0;
`endif

    assign core_stall = stall;
    assign core_rdata = mem_rdata;

    // Memory port mux: host head when it owns the slot, otherwise the core
    // passes straight through (its enables are zero when it is idle).
    always_comb begin
        mem_en    = core_en;
        mem_wr_en = core_en && core_wr_en;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        if (hostIssue) begin
            mem_en    = 1'b1;
            mem_wr_en = headWr;
            mem_addr  = fifoAddr_q[rdPtr_q];
            mem_wdata = fifoData_q[rdPtr_q];
        end
    end

    always_comb begin
        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Read data appears on mem_rdata the cycle after issue; it is forwarded
    // directly during that cycle and captured so it holds afterwards.
    always_comb begin
        rdPending_d = hostIssue && !headWr;
        rdataHold_d = rdPending_q ? mem_rdata : rdataHold_q;
    end

    assign host_rvalid = rdPending_q;
    assign host_rdata  = rdPending_q ? mem_rdata : rdataHold_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            rdPending_q <= 1'b0;
            rdataHold_q <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            rdPending_q <= rdPending_d;
            rdataHold_q <= rdataHold_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            fifoWr_q[wrPtr_q]   <= host_wr;
            fifoAddr_q[wrPtr_q] <= host_addr;
            fifoData_q[wrPtr_q] <= host_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed test of dmem_arbiter against a behavioural single-port DMEM
// (synchronous write, one-cycle read latency). Inputs change 1 time unit after
// the rising edge; outputs are checked on the falling edge.
module tb_dmem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        core_en;
    logic        core_wr_en;
    logic [0:7]  core_addr;
    logic [0:63] core_wdata;
    logic [0:63] core_rdata;
    logic        host_req;
    logic        host_wr;
    logic [0:7]  host_addr;
    logic [0:63] host_wdata;
    logic        host_ready;
    logic        host_rvalid;
    logic [0:63] host_rdata;
    logic        mem_en;
    logic        mem_wr_en;
    logic [0:7]  mem_addr;
    logic [0:63] mem_wdata;
    logic [0:63] mem_rdata;
    logic        core_stall;

    int assertCount = 0;
    int failCount   = 0;

    localparam logic [63:0] DATA0 = 64'hDEADBEEF_00000001;
    localparam logic [63:0] DATA_A = 64'h11112222_33334444;
    localparam logic [63:0] DATA_B = 64'h55556666_77778888;
    localparam logic [63:0] DATA_C = 64'hCAFEF00D_12345678;

    dmem_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .core_en     (core_en),
        .core_wr_en  (core_wr_en),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .host_req    (host_req),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ready  (host_ready),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .core_stall  (core_stall)
    );

    always #5 Clock = ~Clock;

    // Behavioural DMEM
    logic [0:63] memArr [0:255];
    always @(posedge Clock) begin
        if (mem_en && mem_wr_en) memArr[mem_addr] <= mem_wdata;
        if (mem_en && !mem_wr_en) mem_rdata <= memArr[mem_addr];
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic sample();
        @(negedge Clock);
    endtask

    task automatic applyStimulus(input logic req, input logic wr,
                                 input logic [7:0] addr, input logic [63:0] data);
        host_req   = req;
        host_wr    = wr;
        host_addr  = addr;
        host_wdata = data;
    endtask

    task automatic applyCore(input logic en, input logic wr,
                             input logic [7:0] addr, input logic [63:0] data);
        core_en    = en;
        core_wr_en = wr;
        core_addr  = addr;
        core_wdata = data;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        Reset = 1'b1;
        applyCore(1'b0, 1'b0, 8'h00, 64'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 64'h0);
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        mem_rdata = '0;
        applyCore(1'b0, 1'b0, 8'h00, 64'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 64'h0);
        tick();
        sample();
        checkOutput("rst_ready",  64'(host_ready),  64'd1);
        checkOutput("rst_rvalid", 64'(host_rvalid), 64'd0);
        checkOutput("rst_stall",  64'(core_stall),  64'd0);
        checkOutput("rst_mem_en", 64'(mem_en),      64'd0);
        tick();
        Reset = 1'b0;

        // 1: host write, core idle
        applyStimulus(1'b1, 1'b1, 8'h10, DATA0);
        sample();
        checkOutput("t1_ready_push", 64'(host_ready), 64'd1);
        checkOutput("t1_no_issue",   64'(mem_en),     64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 64'h0);
        sample();
        checkOutput("t1_mem_en",    64'(mem_en),    64'd1);
        checkOutput("t1_mem_wr_en", 64'(mem_wr_en), 64'd1);
        checkOutput("t1_mem_addr",  64'(mem_addr),  64'h10);
        checkOutput("t1_mem_wdata", mem_wdata,      DATA0);
        checkOutput("t1_ready",     64'(host_ready), 64'd1);
        tick();

        // 2: host read back
        applyStimulus(1'b1, 1'b0, 8'h10, 64'h0);
        sample();
        checkOutput("t2_no_issue", 64'(mem_en), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 64'h0);
        sample();
        checkOutput("t2_mem_rd",   64'({mem_en, mem_wr_en}), 64'b10);
        checkOutput("t2_mem_addr", 64'(mem_addr), 64'h10);
        checkOutput("t2_rvalid_early", 64'(host_rvalid), 64'd0);
        tick();
        sample();
        checkOutput("t2_rvalid",     64'(host_rvalid), 64'd1);
        checkOutput("t2_rdata",      host_rdata,       DATA0);
        checkOutput("t2_core_rdata", core_rdata,       DATA0);
        tick();
        sample();
        checkOutput("t2_rvalid_pulse", 64'(host_rvalid), 64'd0);
        checkOutput("t2_rdata_hold",   host_rdata,       DATA0);

        // Core write pass-through
        tick();
        applyCore(1'b1, 1'b1, 8'h50, DATA_C);
        sample();
        checkOutput("core_wr_ctl",   64'({mem_en, mem_wr_en}), 64'b11);
        checkOutput("core_wr_addr",  64'(mem_addr), 64'h50);
        checkOutput("core_wr_wdata", mem_wdata,     DATA_C);
        tick();

        // 3: core busy while host pushes 5 requests
        applyCore(1'b1, 1'b0, 8'h20, 64'h0);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: applyStimulus(1'b1, 1'b1, 8'h30, DATA_A);
                1: applyStimulus(1'b1, 1'b1, 8'h31, DATA_B);
                2: applyStimulus(1'b1, 1'b0, 8'h30, 64'h0);
                3: applyStimulus(1'b1, 1'b0, 8'h31, 64'h0);
                default: applyStimulus(1'b1, 1'b1, 8'h40, DATA_C);
            endcase
            sample();
            checkOutput($sformatf("t3_ready_%0d", i), 64'(host_ready), (i < 4) ? 64'd1 : 64'd0);
            checkOutput($sformatf("t3_core_addr_%0d", i), 64'(mem_addr), 64'h20);
            checkOutput($sformatf("t3_core_ctl_%0d", i), 64'({mem_en, mem_wr_en}), 64'b10);
            checkOutput($sformatf("t3_stall_%0d", i), 64'(core_stall), 64'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 64'h0);
        sample();
        checkOutput("t3_full", 64'(host_ready), 64'd0);
        checkOutput("t3_hold_addr", 64'(mem_addr), 64'h20);
        tick();

        // 4: core releases, queued ops drain in order
        applyCore(1'b0, 1'b0, 8'h00, 64'h0);
        sample();
        checkOutput("t4_p1_ctl",   64'({mem_en, mem_wr_en}), 64'b11);
        checkOutput("t4_p1_addr",  64'(mem_addr), 64'h30);
        checkOutput("t4_p1_wdata", mem_wdata, DATA_A);
        checkOutput("t4_p1_ready", 64'(host_ready), 64'd0);
        tick();
        sample();
        checkOutput("t4_p2_ctl",   64'({mem_en, mem_wr_en}), 64'b11);
        checkOutput("t4_p2_addr",  64'(mem_addr), 64'h31);
        checkOutput("t4_p2_wdata", mem_wdata, DATA_B);
        checkOutput("t4_p2_ready", 64'(host_ready), 64'd1);
        tick();
        sample();
        checkOutput("t4_p3_ctl",  64'({mem_en, mem_wr_en}), 64'b10);
        checkOutput("t4_p3_addr", 64'(mem_addr), 64'h30);
        tick();
        sample();
        checkOutput("t4_p4_ctl",    64'({mem_en, mem_wr_en}), 64'b10);
        checkOutput("t4_p4_addr",   64'(mem_addr), 64'h31);
        checkOutput("t4_p4_rvalid", 64'(host_rvalid), 64'd1);
        checkOutput("t4_p4_rdata",  host_rdata, DATA_A);
        tick();
        sample();
        checkOutput("t4_p5_idle",   64'(mem_en), 64'd0);
        checkOutput("t4_p5_rvalid", 64'(host_rvalid), 64'd1);
        checkOutput("t4_p5_rdata",  host_rdata, DATA_B);
        tick();
        sample();
        checkOutput("t4_p6_rvalid", 64'(host_rvalid), 64'd0);
        checkOutput("t4_p6_hold",   host_rdata, DATA_B);
        tick();

        // 5: reset with queued requests and a pending read return
        applyCore(1'b1, 1'b0, 8'h20, 64'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h30, 64'h0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 64'h0);
        applyCore(1'b0, 1'b0, 8'h00, 64'h0);
        sample();
        checkOutput("t5_issue_addr", 64'(mem_addr), 64'h30);
        checkOutput("t5_issue_en",   64'(mem_en),   64'd1);
        tick();
        Reset = 1'b1;
        applyCore(1'b1, 1'b0, 8'h20, 64'h0);
        sample();
        checkOutput("t5_pre_rvalid", 64'(host_rvalid), 64'd1);
        tick();
        Reset = 1'b0;
        applyCore(1'b0, 1'b0, 8'h00, 64'h0);
        sample();
        checkOutput("t5_rvalid", 64'(host_rvalid), 64'd0);
        checkOutput("t5_mem_en", 64'(mem_en),      64'd0);
        checkOutput("t5_ready",  64'(host_ready),  64'd1);
        tick();
        sample();
        checkOutput("t5_mem_en2", 64'(mem_en), 64'd0);
        tick();

`ifdef STARVE_GUARD_EN
        // 6: forced host slot after MAX_WAIT blocked cycles
        doReset();
        applyCore(1'b1, 1'b0, 8'h20, 64'h0);
        applyStimulus(1'b1, 1'b0, 8'h31, 64'h0);
        sample();
        checkOutput("t6_c0_stall", 64'(core_stall), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 64'h0);
        for (int i = 1; i <= 8; i++) begin
            sample();
            checkOutput($sformatf("t6_c%0d_stall", i), 64'(core_stall), 64'd0);
            checkOutput($sformatf("t6_c%0d_addr", i), 64'(mem_addr), 64'h20);
            tick();
        end
        sample();
        checkOutput("t6_c9_stall", 64'(core_stall), 64'd1);
        checkOutput("t6_c9_ctl",   64'({mem_en, mem_wr_en}), 64'b10);
        checkOutput("t6_c9_addr",  64'(mem_addr), 64'h31);
        tick();
        sample();
        checkOutput("t6_c10_stall",  64'(core_stall), 64'd0);
        checkOutput("t6_c10_addr",   64'(mem_addr), 64'h20);
        checkOutput("t6_c10_rvalid", 64'(host_rvalid), 64'd1);
        checkOutput("t6_c10_rdata",  host_rdata, DATA_B);
        tick();
`else
        // Without the guard the host waits indefinitely behind the core.
        doReset();
        applyCore(1'b1, 1'b0, 8'h20, 64'h0);
        applyStimulus(1'b1, 1'b0, 8'h31, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 64'h0);
        for (int i = 1; i <= 12; i++) begin
            sample();
            checkOutput($sformatf("t6_c%0d_stall", i), 64'(core_stall), 64'd0);
            checkOutput($sformatf("t6_c%0d_addr", i), 64'(mem_addr), 64'h20);
            tick();
        end
        applyCore(1'b0, 1'b0, 8'h00, 64'h0);
        sample();
        checkOutput("t6_late_addr", 64'(mem_addr), 64'h31);
        tick();
        sample();
        checkOutput("t6_late_rdata", host_rdata, DATA_B);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
